// File: rtl/fft_seq_ctrl_pkg.sv
// fft_seq_ctrl shared types.
// Frame lifecycle states and configuration helpers.
package fft_seq_ctrl_pkg;

  localparam int unsigned MIN_FFT_SIZE = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_bfly_agu.sv
// Butterfly address generator: (stage, j) -> operand pair and twiddle.
// Purely combinational, in-place radix-2 DIT addressing.
module fft_seq_ctrl_bfly_agu #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned STAGE_W = 2
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [ADDR_W-2:0]  j,
  output logic [ADDR_W-1:0]  a,
  output logic [ADDR_W-1:0]  b,
  output logic [ADDR_W-2:0]  tw
);

  localparam int unsigned TW_W = ADDR_W - 1;

  logic [ADDR_W-1:0] jx;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;

  always_comb begin
    jx   = {1'b0, j};
    half = ADDR_W'(1) << stage;
    pos  = jx & (half - ADDR_W'(1));
    grp  = (jx >> stage) << (int'(stage) + 1);
    a    = grp | pos;
    b    = a + half;
    tw   = TW_W'(pos << (TW_W - int'(stage)));
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT frame sequencer: bit-reversed load, staged butterfly issue
// with a writeback barrier per stage, natural-order drain.
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter int unsigned FFT_SIZE     = 4096,
  parameter int unsigned BFLY_LATENCY = 6,
  localparam int unsigned ADDR_W  = $clog2(FFT_SIZE),
  localparam int unsigned STAGE_W = $clog2($clog2(FFT_SIZE))
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fft_go,
  output logic               fft_busy,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic               ld_we,
  output logic [ADDR_W-1:0]  ld_addr,
  output logic               bf_valid,
  output logic [ADDR_W-1:0]  bf_addr_a,
  output logic [ADDR_W-1:0]  bf_addr_b,
  output logic [ADDR_W-2:0]  tw_addr,
  output logic [STAGE_W-1:0] bf_stage,
  input  logic               wb_valid,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               frame_err
);

  localparam int unsigned TW_W  = ADDR_W - 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  LD_LAST = ADDR_W'(FFT_SIZE - 1);
  localparam logic [TW_W-1:0]    J_LAST  = TW_W'(FFT_SIZE / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST  = STAGE_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]   RD_N    = CNT_W'(FFT_SIZE);
  localparam logic [CNT_W-1:0]   RD_LAST = CNT_W'(FFT_SIZE - 1);

  if (!is_pow2(FFT_SIZE) || FFT_SIZE < MIN_FFT_SIZE ||
      BFLY_LATENCY == 0) begin : g_bad_cfg
    $error("fft_seq_ctrl: unsupported FFT_SIZE or BFLY_LATENCY");
  end

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [STAGE_W-1:0] stage;
  logic [TW_W-1:0]    j;
  logic [TW_W-1:0]    wb_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [ADDR_W-1:0]  agu_a;
  logic [ADDR_W-1:0]  agu_b;
  logic [TW_W-1:0]    agu_tw;
  logic               ld_last;

  fft_seq_ctrl_bfly_agu #(
    .ADDR_W  (ADDR_W),
    .STAGE_W (STAGE_W)
  ) u_agu (
    .stage (stage),
    .j     (j),
    .a     (agu_a),
    .b     (agu_b),
    .tw    (agu_tw)
  );

  assign fft_busy      = state != S_IDLE;
  assign s_axis_tready = state == S_LOAD;
  assign ld_we         = s_axis_tvalid & s_axis_tready;
  assign ld_last       = cnt == LD_LAST;
  assign rd_addr       = rd_cnt[ADDR_W-1:0];
  assign rd_en         = (state == S_DRAIN) &
                         (!m_axis_tvalid | m_axis_tready) &
                         (rd_cnt < RD_N);

  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign ld_addr[i] = cnt[ADDR_W-1-i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      stage         <= '0;
      j             <= '0;
      wb_cnt        <= '0;
      rd_cnt        <= '0;
      bf_valid      <= 1'b0;
      bf_addr_a     <= '0;
      bf_addr_b     <= '0;
      tw_addr       <= '0;
      bf_stage      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bf_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fft_go) begin
            state     <= S_LOAD;
            cnt       <= '0;
            frame_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_we) begin
            // length is fixed at N; tlast only flags a framing error
            if (s_axis_tlast != ld_last) frame_err <= 1'b1;
            cnt <= cnt + ADDR_W'(1);
            if (ld_last) begin
              state  <= S_ISSUE;
              stage  <= '0;
              j      <= '0;
              wb_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          bf_valid  <= 1'b1;
          bf_addr_a <= agu_a;
          bf_addr_b <= agu_b;
          tw_addr   <= agu_tw;
          bf_stage  <= stage;
          j         <= j + TW_W'(1);
          if (j == J_LAST) state <= S_WAIT;
          if (wb_valid) wb_cnt <= wb_cnt + TW_W'(1);
        end
        S_WAIT: begin
          // next stage reads what this one writes: wait for every writeback
          if (wb_valid) begin
            if (wb_cnt == J_LAST) begin
              wb_cnt <= '0;
              j      <= '0;
              if (stage == S_LAST) begin
                state  <= S_DRAIN;
                rd_cnt <= '0;
              end else begin
                state <= S_ISSUE;
                stage <= stage + STAGE_W'(1);
              end
            end else begin
              wb_cnt <= wb_cnt + TW_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (rd_en) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= rd_cnt == RD_LAST;
            rd_cnt        <= rd_cnt + CNT_W'(1);
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state         <= S_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl at N=8 (L=3) and N=4096 (L=6).
// Expected addressing comes from a group/offset butterfly model.
module tb_fft_seq_ctrl;

  localparam int N   = 8;
  localparam int LG  = 3;
  localparam int L   = 3;
  localparam int NI  = LG * N / 2;
  localparam int BN  = 4096;
  localparam int BLG = 12;
  localparam int BL  = 6;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         fft_go = 0, s_axis_tvalid = 0, s_axis_tlast = 0;
  logic         m_axis_tready = 0;
  logic         fft_busy, s_axis_tready, ld_we, bf_valid, wb_valid;
  logic         rd_en, m_axis_tvalid, m_axis_tlast, frame_err;
  logic [2:0]   ld_addr, bf_addr_a, bf_addr_b, rd_addr;
  logic [1:0]   tw_addr, bf_stage;

  fft_seq_ctrl #(.FFT_SIZE(N), .BFLY_LATENCY(L)) u_dut (
    .clk(clk), .reset(reset), .fft_go(fft_go), .fft_busy(fft_busy),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .tw_addr(tw_addr), .bf_stage(bf_stage), .wb_valid(wb_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .frame_err(frame_err)
  );

  logic         big_go = 0, big_tvalid = 0, big_tlast = 0, big_tready = 0;
  logic         big_busy, big_sready, big_ld_we, big_bf_valid, big_wb;
  logic         big_rd_en, big_mvalid, big_mlast, big_err;
  logic [11:0]  big_ld_addr, big_a, big_b, big_rd_addr;
  logic [10:0]  big_tw;
  logic [3:0]   big_stage;

  fft_seq_ctrl #(.FFT_SIZE(BN), .BFLY_LATENCY(BL)) u_big (
    .clk(clk), .reset(reset), .fft_go(big_go), .fft_busy(big_busy),
    .s_axis_tvalid(big_tvalid), .s_axis_tready(big_sready),
    .s_axis_tlast(big_tlast), .ld_we(big_ld_we), .ld_addr(big_ld_addr),
    .bf_valid(big_bf_valid), .bf_addr_a(big_a), .bf_addr_b(big_b),
    .tw_addr(big_tw), .bf_stage(big_stage), .wb_valid(big_wb),
    .rd_en(big_rd_en), .rd_addr(big_rd_addr), .m_axis_tvalid(big_mvalid),
    .m_axis_tready(big_tready), .m_axis_tlast(big_mlast),
    .frame_err(big_err)
  );

  // butterfly pipelines and 1-cycle-latency RAMs holding their address
  logic [L-1:0]  wb_pipe = '0;
  logic [BL-1:0] big_pipe = '0;
  logic [2:0]    ram_q = '0;
  logic [11:0]   big_ram_q = '0;
  int            big_iss = 0;
  assign wb_valid = wb_pipe[L-1];
  assign big_wb   = big_pipe[BL-1];
  always @(posedge clk) begin
    wb_pipe  <= {wb_pipe[L-2:0], bf_valid};
    big_pipe <= {big_pipe[BL-2:0], big_bf_valid};
    if (rd_en) ram_q <= rd_addr;
    if (big_rd_en) big_ram_q <= big_rd_addr;
    if (big_bf_valid) big_iss <= big_iss + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int rev(input int v, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++)
      if (((v >> b) & 1) != 0) r += 1 << (bits - 1 - b);
    return r;
  endfunction

  int ex_a[NI], ex_b[NI], ex_tw[NI], ex_s[NI];
  int iss_tot = 0, iss_base = 0, wb_seen = 0, wb_base = 0;
  bit mon_en = 0;
  int k;
  bit last_err = 0;

  always @(negedge clk) begin
    if (bf_valid) begin
      if (mon_en) begin
        k = iss_tot - iss_base;
        if (k < NI) begin
          chk("bf_addr_a", bf_addr_a, ex_a[k]);
          chk("bf_addr_b", bf_addr_b, ex_b[k]);
          chk("tw_addr", tw_addr, ex_tw[k]);
          chk("bf_stage", bf_stage, ex_s[k]);
          chk("stage_barrier", (wb_seen - wb_base) >= ex_s[k] * (N / 2), 1);
        end else begin
          chk("issue_overflow", k, NI - 1);
        end
      end
      iss_tot++;
    end
    if (wb_valid) wb_seen++;
  end

  task automatic go();
    chk("err_sticky", frame_err, last_err);
    fft_go = 1;
    @(posedge clk); #1;
    fft_go = 0;
    @(negedge clk);
    chk("go_busy", fft_busy, 1);
    chk("go_err_clr", frame_err, 0);
    chk("go_tready", s_axis_tready, 1);
    @(posedge clk); #1;
  endtask

  // ends at the negedge following the N-th handshake
  task automatic load(input int tl, input bit gaps);
    bit exp_err = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        s_axis_tvalid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      s_axis_tvalid = 1;
      s_axis_tlast  = (i == tl);
      @(negedge clk);
      chk("ld_we", ld_we, 1);
      chk("ld_addr", ld_addr, rev(i, LG));
      chk("ld_err", frame_err, exp_err);
      if ((i == tl) != (i == N - 1)) exp_err = 1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
    @(negedge clk);
    chk("ld_done_tready", s_axis_tready, 0);
    chk("ld_done_err", frame_err, exp_err);
    last_err = exp_err;
    iss_base = iss_tot;
    wb_base  = wb_seen;
  endtask

  task automatic wait_drain(output int c);
    c = 0;
    while (!rd_en && c < 500) begin @(negedge clk); c++; end
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd);
    bit [3:0] pat = 4'b1001;
    int beats = 0;
    int cyc = 0;
    while (beats < N && cyc < 400) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_order", ram_q, beats);
        chk("beat_tlast", m_axis_tlast, beats == N - 1);
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_axis_tready = 0;
    chk("beat_count", beats, N);
    @(negedge clk);
    chk("drain_busy", fft_busy, 0);
    chk("drain_tvalid", m_axis_tvalid, 0);
    chk("iss_count", iss_tot - iss_base, NI);
    chk("wb_count", wb_seen - wb_base, NI);
    @(posedge clk); #1;
  endtask

  initial begin
    int c, errs, beats, half, idx;
    idx = 0;
    for (int s = 0; s < LG; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++)
        for (int q = 0; q < half; q++) begin
          ex_a[idx]  = g * 2 * half + q;
          ex_b[idx]  = g * 2 * half + q + half;
          ex_tw[idx] = q * (N / (2 * half));
          ex_s[idx]  = s;
          idx++;
        end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", fft_busy, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_rd_en", rd_en, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // frame 1: clean frame, 1,0,0,1 backpressure, compute time
    mon_en = 1;
    go();
    load(N - 1, 1);
    wait_drain(c);
    chk_rng("compute_cycles", c, LG * (N / 2 + L + 1) - 2,
            LG * (N / 2 + L + 1) + 2);
    drain(0);

    // frame 2: fft_go during ISSUE is ignored
    go();
    load(N - 1, 1);
    @(posedge clk); #1;
    fft_go = 1;
    @(posedge clk); #1;
    fft_go = 0;
    @(negedge clk);
    chk("ign_busy", fft_busy, 1);
    chk("ign_tready", s_axis_tready, 0);
    wait_drain(c);
    drain(1);

    // frame 3: early tlast; frame 4: missing tlast
    go();
    load(3, 1);
    wait_drain(c);
    drain(1);
    go();
    load(-1, 0);
    wait_drain(c);
    drain(0);

    // frame 5: reset in the middle of ISSUE
    mon_en = 0;
    go();
    load(N - 1, 0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1;
    #1;
    chk("mid_rst_busy", fft_busy, 0);
    chk("mid_rst_bf_valid", bf_valid, 0);
    chk("mid_rst_addr_a", bf_addr_a, 0);
    chk("mid_rst_addr_b", bf_addr_b, 0);
    chk("mid_rst_tw", tw_addr, 0);
    chk("mid_rst_stage", bf_stage, 0);
    chk("mid_rst_ld_addr", ld_addr, 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    last_err = 0;
    @(posedge clk); #1;
    reset = 0;

    // frame 6: fresh frame while stale writebacks land
    mon_en = 1;
    go();
    load(N - 1, 1);
    wait_drain(c);
    drain(1);

    // large frame: addresses, compute time, drain order
    big_go = 1;
    @(posedge clk); #1;
    big_go = 0;
    errs = 0;
    for (int i = 0; i < BN; i++) begin
      big_tvalid = 1;
      big_tlast  = (i == BN - 1);
      @(negedge clk);
      if (!big_ld_we || big_ld_addr != 12'(rev(i, BLG))) errs++;
      @(posedge clk); #1;
    end
    big_tvalid = 0;
    big_tlast  = 0;
    chk("big_ld_addr_errs", errs, 0);
    @(negedge clk);
    chk("big_err", big_err, 0);
    chk("big_tready", big_sready, 0);
    c = 0;
    while (!big_rd_en && c < 40000) begin @(negedge clk); c++; end
    chk_rng("big_compute_cycles", c, BLG * (BN / 2 + BL + 1) - 2,
            BLG * (BN / 2 + BL + 1) + 2);
    chk("big_iss_count", big_iss, BLG * BN / 2);
    @(posedge clk); #1;
    errs = 0;
    beats = 0;
    c = 0;
    while (beats < BN && c < 20000) begin
      big_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (big_mvalid && big_tready) begin
        if (big_ram_q != 12'(beats) || big_mlast != (beats == BN - 1))
          errs++;
        beats++;
      end
      @(posedge clk); #1;
      c++;
    end
    big_tready = 0;
    chk("big_beats", beats, BN);
    chk("big_order_errs", errs, 0);
    @(negedge clk);
    chk("big_busy_end", big_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
